// File: rtl/wb_tile_bus_rr.sv
// Multi-master Wishbone B3 tile interconnect: round-robin arbitration, base/mask slave decode,
// and error termination of unmapped or stalled accesses so no slave can hang the tile.
module wb_tile_bus_rr #(
    parameter int MASTERS = 2,
    parameter int SLAVES = 10,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT = 255,
    localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           rst_sys_n,
    input  logic [MASTERS*ADDR_WIDTH-1:0]  m_adr_i,
    input  logic [MASTERS*DATA_WIDTH-1:0]  m_dat_i,
    input  logic [MASTERS*SEL_WIDTH-1:0]   m_sel_i,
    input  logic [MASTERS-1:0]             m_cyc_i,
    input  logic [MASTERS-1:0]             m_stb_i,
    input  logic [MASTERS-1:0]             m_we_i,
    output logic [DATA_WIDTH-1:0]          m_dat_o,
    output logic [MASTERS-1:0]             m_ack_o,
    output logic [MASTERS-1:0]             m_err_o,
    output logic [MASTERS-1:0]             m_rty_o,
    output logic [ADDR_WIDTH-1:0]          s_adr_o,
    output logic [DATA_WIDTH-1:0]          s_dat_o,
    output logic [SEL_WIDTH-1:0]           s_sel_o,
    output logic                           s_we_o,
    output logic [SLAVES-1:0]              s_cyc_o,
    output logic [SLAVES-1:0]              s_stb_o,
    input  logic [SLAVES*DATA_WIDTH-1:0]   s_dat_i,
    input  logic [SLAVES-1:0]              s_ack_i,
    input  logic [SLAVES-1:0]              s_err_i,
    input  logic [SLAVES-1:0]              s_rty_i,
    output logic                           bus_err_o,
    output logic [2:0]                     bus_err_master_o,
    output logic [1:0]                     dbg_state_o
);

    // Handshake: cyc&stb is the request-valid; exactly one of ack/err/rty in the same
    // cycle terminates it. Terminations pass through combinationally with zero latency.

    localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   grant_q, grant_d;
    logic [MW-1:0]   ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [2:0]      err_master_q, err_master_d;

    logic [ADDR_WIDTH-1:0] g_adr;
    logic [DATA_WIDTH-1:0] g_dat;
    logic [SEL_WIDTH-1:0]  g_sel;
    logic                  g_we, g_cyc, g_stb;

    logic [SLAVES-1:0]     sel_oh;
    logic                  hit;
    logic [DATA_WIDTH-1:0] sl_dat;
    logic                  sl_ack, sl_err, sl_rty;

    logic                  req_valid, tmo, term;
    logic                  rr_found;
    logic [MW-1:0]         rr_pick;

    always_comb begin
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_we  = 1'b0;
        g_cyc = 1'b0;
        g_stb = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            if (grant_q == MW'(i)) begin
                g_adr = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                g_dat = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                g_sel = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
                g_we  = m_we_i[i];
                g_cyc = m_cyc_i[i];
                g_stb = m_stb_i[i];
            end
        end
    end

    // Descending scan so the lowest-index matching window ends up selected.
    always_comb begin
        sel_oh = '0;
        hit    = 1'b0;
        for (int s = SLAVES - 1; s >= 0; s--) begin
            if ((g_adr & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH]) begin
                sel_oh    = '0;
                sel_oh[s] = 1'b1;
                hit       = 1'b1;
            end
        end
    end

    always_comb begin
        sl_dat = '0;
        sl_ack = 1'b0;
        sl_err = 1'b0;
        sl_rty = 1'b0;
        for (int s = 0; s < SLAVES; s++) begin
            if (sel_oh[s]) begin
                sl_dat = s_dat_i[s*DATA_WIDTH +: DATA_WIDTH];
                sl_ack = s_ack_i[s];
                sl_err = s_err_i[s];
                sl_rty = s_rty_i[s];
            end
        end
    end

    assign req_valid = (state_q == ST_GRANT) && g_cyc && g_stb;
    assign tmo       = (cnt_q == 8'(TIMEOUT));
    assign term      = req_valid && hit && (sl_ack || sl_err || sl_rty);

    // First requester strictly after the pointer, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        for (int k = 1; k <= MASTERS; k++) begin
            for (int c = 0; c < MASTERS; c++) begin
                if (!rr_found && m_cyc_i[c] && (((int'(ptr_q) + k) % MASTERS) == c)) begin
                    rr_found = 1'b1;
                    rr_pick  = MW'(c);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        err_master_d = err_master_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rr_found) begin
                    grant_d = rr_pick;
                    ptr_d   = rr_pick;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!g_cyc) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (g_stb && !hit) begin
                    cnt_d        = '0;
                    err_master_d = 3'(grant_q);
                    state_d      = ST_ERR;
                end else if (g_stb && tmo && !term) begin
                    cnt_d        = '0;
                    err_master_d = 3'(grant_q);
                    state_d      = ST_ERR;
                end else if (g_stb && !term) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_ERR: begin
                cnt_d   = '0;
                state_d = g_cyc ? ST_GRANT : ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_sys_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            ptr_q        <= MW'(MASTERS - 1);
            cnt_q        <= '0;
            err_master_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            err_master_q <= err_master_d;
        end
    end

    // A timed-out access loses its slave strobe, but a termination arriving that cycle still wins.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = '0;
        s_stb_o = '0;
        if (state_q != ST_IDLE) begin
            s_adr_o = g_adr;
            s_dat_o = g_dat;
            s_sel_o = g_sel;
            s_we_o  = g_we;
        end
        if ((state_q == ST_GRANT) && hit && !tmo) begin
            s_cyc_o = g_cyc ? sel_oh : '0;
            s_stb_o = (g_cyc && g_stb) ? sel_oh : '0;
        end
    end

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        m_dat_o = '0;
        if (req_valid && hit) begin
            m_dat_o = sl_dat;
        end
        for (int i = 0; i < MASTERS; i++) begin
            if (grant_q == MW'(i)) begin
                m_ack_o[i] = req_valid && hit && sl_ack;
                m_rty_o[i] = req_valid && hit && sl_rty;
                m_err_o[i] = (req_valid && hit && sl_err) || (state_q == ST_ERR);
            end
        end
    end

    assign bus_err_o        = (state_q == ST_ERR);
    assign bus_err_master_o = err_master_q;
    assign dbg_state_o      = state_q;

endmodule
